// File: rtl/line_store_pkg.sv
// ---------------------------------------------------------------------------
// line_store_pkg
// Shared constants and types for the playfield line store.
//   LINES / WIDTH / AW : default geometry of the line store
//   PW                 : width of the pixel (bit-within-line) index
//   state_t            : controller states (CLEAR only reachable when
//                        LINE_STORE_CLEAR_ON_RESET_EN is defined)
// ---------------------------------------------------------------------------
package line_store_pkg;

    localparam int LINES = 640;
    localparam int WIDTH = 480;
    localparam int AW    = 10;
    localparam int PW    = 9;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
// Line-wide storage: one write port and two independent registered read
// ports. Reads return the contents before a same-cycle write to the same
// address (read-before-write); callers handle forwarding themselves.
// Ports:
//   clk_i                 clock
//   we_i/waddr_i/wdata_i  write port
//   ra_addr_i/ra_data_o   read port A, one cycle latency
//   rb_addr_i/rb_data_o   read port B, one cycle latency
// Addresses are expected to be < DEPTH; range checks live in the caller.
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 480,
    parameter int AW    = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    ra_addr_i,
    output logic [WIDTH-1:0] ra_data_o,
    input  logic [AW-1:0]    rb_addr_i,
    output logic [WIDTH-1:0] rb_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        ra_q <= mem[ra_addr_i];
        rb_q <= mem[rb_addr_i];
    end

    assign ra_data_o = ra_q;
    assign rb_data_o = rb_q;

endmodule

// File: rtl/line_store_ctrl.sv
// ---------------------------------------------------------------------------
// line_store_ctrl
// Owns the playfield line store. Sweeps h_addr across all lines, presenting
// DisLine = mem[h_addr], accepts line write-backs, and serves a registered
// single-pixel read port for the VGA stage.
// Ports:
//   clk, rst (sync, active-high)
//   h_addr      current sweep line address (held HOLD cycles per line)
//   DisLine     contents of line h_addr, bit 0 = first pixel
//   FallLine, w_addr, ready   write-back port, one line per cycle
//   vga_x, vga_y, pix         pixel query, pix one cycle after the query
//   sweep_done  one-cycle pulse when h_addr wraps to 0
// Build option:
//   LINE_STORE_CLEAR_ON_RESET_EN : after reset, zero every line (CLEAR state)
//   before sweeping; writes are ignored meanwhile. Undefined: store contents
//   survive reset.
// ---------------------------------------------------------------------------
module line_store_ctrl #(
    parameter int LINES = line_store_pkg::LINES,
    parameter int WIDTH = line_store_pkg::WIDTH,
    parameter int AW    = line_store_pkg::AW,
    parameter int HOLD  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [AW-1:0]                h_addr,
    output logic [WIDTH-1:0]             DisLine,
    input  logic [WIDTH-1:0]             FallLine,
    input  logic [AW-1:0]                w_addr,
    input  logic                         ready,
    input  logic [AW-1:0]                vga_x,
    input  logic [line_store_pkg::PW-1:0] vga_y,
    output logic                         pix,
    output logic                         sweep_done
);

    import line_store_pkg::*;

    if (HOLD < 2) begin : g_hold_chk
        $error("line_store_ctrl: HOLD must be >= 2");
    end

    localparam int                CW         = $clog2(HOLD);
    localparam logic [AW-1:0]     LAST_LINE  = AW'(LINES - 1);
    localparam logic [CW-1:0]     LAST_DWELL = CW'(HOLD - 1);
`ifdef LINE_STORE_CLEAR_ON_RESET_EN
    localparam state_t            RST_STATE  = CLEAR;
`else
    localparam state_t            RST_STATE  = SWEEP;
`endif

    state_t            state_q, state_d;
    logic [AW-1:0]     h_addr_q, h_addr_d;
    logic [AW-1:0]     clr_q, clr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sweep_done_q, sweep_done_d;

    logic              zero_q;
    logic              byp_q;
    logic [WIDTH-1:0]  byp_line_q;
    logic              pix_vld_q;
    logic [PW-1:0]     vga_y_q;

    logic              last_dwell;
    logic              w_ok;
    logic              x_ok;
    logic              y_ok;
    logic [AW-1:0]     next_addr;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     pix_addr;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  sweep_line;
    logic [WIDTH-1:0]  pix_line;

    // Address and range decode
    always_comb begin
        last_dwell = (cnt_q == LAST_DWELL);
        next_addr  = (h_addr_q == LAST_LINE) ? '0 : h_addr_q + 1'b1;
        // The sweep read always targets the line h_addr will hold next cycle:
        // the following line during the last dwell cycle, the current one
        // otherwise. That keeps DisLine and h_addr changing together.
        rd_addr    = ((state_q == SWEEP) && last_dwell) ? next_addr : h_addr_q;
        w_ok       = ready && (int'(w_addr) < LINES) && (state_q == SWEEP) && !rst;
        x_ok       = (int'(vga_x) < LINES);
        y_ok       = (int'(vga_y) < WIDTH);
        pix_addr   = x_ok ? vga_x : '0;
    end

    // Sweep / clear FSM, next state and write-port steering
    always_comb begin
        state_d      = state_q;
        h_addr_d     = h_addr_q;
        cnt_d        = cnt_q;
        clr_d        = clr_q;
        sweep_done_d = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = w_addr;
        ram_wdata    = FallLine;

        case (state_q)
            SWEEP: begin
                ram_we = w_ok;
                if (last_dwell) begin
                    cnt_d        = '0;
                    h_addr_d     = next_addr;
                    sweep_done_d = (h_addr_q == LAST_LINE);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEAR: begin
                ram_we    = !rst;
                ram_waddr = clr_q;
                ram_wdata = '0;
                h_addr_d  = '0;
                cnt_d     = '0;
                if (clr_q == LAST_LINE) begin
                    clr_d   = '0;
                    state_d = SWEEP;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            h_addr_q     <= '0;
            cnt_q        <= '0;
            clr_q        <= '0;
            sweep_done_q <= 1'b0;
            zero_q       <= 1'b1;
            byp_q        <= 1'b0;
            pix_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_addr_q     <= h_addr_d;
            cnt_q        <= cnt_d;
            clr_q        <= clr_d;
            sweep_done_q <= sweep_done_d;
            // Blank DisLine for the cycle after reset and through CLEAR,
            // including the first SWEEP cycle that follows it.
            zero_q       <= (state_q == CLEAR);
            // RAM read is read-before-write, so a write landing on the line
            // just read must be forwarded from the write data instead.
            byp_q        <= w_ok && (w_addr == rd_addr);
            pix_vld_q    <= (state_q == SWEEP) && x_ok && y_ok;
        end
    end

    // Data registers (no reset needed; qualified by the control flags above)
    always_ff @(posedge clk) begin
        byp_line_q <= FallLine;
        vga_y_q    <= vga_y;
    end

    line_ram #(
        .DEPTH (LINES),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .ra_addr_i (rd_addr),
        .ra_data_o (sweep_line),
        .rb_addr_i (pix_addr),
        .rb_data_o (pix_line)
    );

    // Output stage
    assign h_addr     = h_addr_q;
    assign sweep_done = sweep_done_q;
    assign DisLine    = zero_q ? '0 : (byp_q ? byp_line_q : sweep_line);
    assign pix        = pix_vld_q & pix_line[vga_y_q];

endmodule

// File: tb/tb_line_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_store_ctrl
// Directed self-checking bench for line_store_ctrl (HOLD = 4, 640 x 480).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_line_store_ctrl;

    localparam int L = 640;
    localparam int W = 480;
    localparam int A = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [A-1:0]  h_addr;
    logic [W-1:0]  DisLine;
    logic [W-1:0]  FallLine;
    logic [A-1:0]  w_addr;
    logic          ready;
    logic [A-1:0]  vga_x;
    logic [8:0]    vga_y;
    logic          pix;
    logic          sweep_done;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  model [L];
    logic [W-1:0]  ones;
    logic [W-1:0]  pat6;

    always #5 clk = ~clk;

    line_store_ctrl #(
        .LINES (L),
        .WIDTH (W),
        .AW    (A),
        .HOLD  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .h_addr     (h_addr),
        .DisLine    (DisLine),
        .FallLine   (FallLine),
        .w_addr     (w_addr),
        .ready      (ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .pix        (pix),
        .sweep_done (sweep_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the first cycle of a dwell on line 'target'.
    task automatic wait_h(input int target);
        int n;
        n = 0;
        while (h_addr === A'(target) && n < 3000) begin tick(); n++; end
        while (h_addr !== A'(target) && n < 3000) begin tick(); n++; end
        checks++;
        if (h_addr !== A'(target)) begin
            errors++;
            $display("FAIL wait_h: h_addr=%0d expected %0d (timeout)", h_addr, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; w_addr = '0; FallLine = '0; vga_x = '0; vga_y = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (h_addr !== '0) begin errors++; $display("FAIL rst_h_addr: got %0d expected 0", h_addr); end
        checks++; if (DisLine !== '0) begin errors++; $display("FAIL rst_DisLine: got %0h expected 0", DisLine); end
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL rst_pix: got %0b expected 0", pix); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL rst_sweep_done: got %0b expected 0", sweep_done); end
`ifndef LINE_STORE_CLEAR_ON_RESET_EN
        tick();
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %0b expected 0", sweep_done); end
        tick(); tick();
        checks++; if (h_addr !== '0) begin errors++; $display("FAIL rst_dwell0: got %0d expected 0", h_addr); end
        tick();
        checks++; if (h_addr !== 10'd1) begin errors++; $display("FAIL rst_step1: got %0d expected 1", h_addr); end
`endif
    endtask

`ifdef LINE_STORE_CLEAR_ON_RESET_EN
    task automatic test_clear();
        int bad;
        for (int i = 0; i < 650; i++) tick();
        ready = 1'b1;
        for (int k = 0; k < L; k++) begin w_addr = A'(k); FallLine = ones; tick(); end
        ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        ready = 1'b1; w_addr = 10'd3; FallLine = ones; vga_x = 10'd3; vga_y = 9'd0;
        bad = 0;
        for (int i = 0; i < L; i++) begin
            if (h_addr !== '0 || DisLine !== '0 || pix !== 1'b0) bad++;
            tick();
        end
        ready = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_phase: %0d bad cycles, required 0", bad); end
        for (int k = 0; k < L; k++) model[k] = '0;
        bad = 0;
        for (int i = 0; i < L * 4; i++) begin
            if (h_addr !== A'(i / 4) || DisLine !== '0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sweep: %0d bad cycles, required 0", bad); end
        checks++; if (sweep_done !== 1'b1 || h_addr !== '0) begin
            errors++; $display("FAIL clear_wrap: sweep_done=%0b h_addr=%0d expected 1 and 0", sweep_done, h_addr);
        end
    endtask
`endif

    task automatic test_preload();
        ready = 1'b1;
        for (int k = 0; k < L; k++) begin
            w_addr   = A'(k);
            FallLine = W'(k);
            model[k] = W'(k);
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic test_sweep();
        int n, bad, first_i, first_h, pulses;
        n = 0;
        while (sweep_done !== 1'b1 && n < 3000) begin tick(); n++; end
        checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL sweep_pulse: got %0b expected 1 (timeout)", sweep_done); end
        checks++; if (h_addr !== '0) begin errors++; $display("FAIL sweep_wrap_addr: got %0d expected 0", h_addr); end
        bad = 0; first_i = -1; first_h = 0; pulses = 0;
        for (int i = 0; i < L * 4; i++) begin
            if (sweep_done === 1'b1) pulses++;
            if (h_addr !== A'(i / 4) || DisLine !== model[i / 4] ||
                sweep_done !== (i == 0)) begin
                if (bad == 0) begin first_i = i; first_h = int'(h_addr); end
                bad++;
            end
            tick();
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL sweep_seq: %0d bad cycles, first at cycle %0d with h_addr=%0d expected %0d", bad, first_i, first_h, first_i / 4);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL sweep_pulse_count: got %0d expected 1", pulses); end
        checks++; if (sweep_done !== 1'b1 || h_addr !== '0) begin
            errors++; $display("FAIL sweep_period: sweep_done=%0b h_addr=%0d expected 1 and 0", sweep_done, h_addr);
        end
    endtask

    task automatic test_write_bypass();
        wait_h(5);
        ready = 1'b1; w_addr = 10'd5; FallLine = ones;
        tick();
        ready = 1'b0; model[5] = ones;
        checks++; if (DisLine !== ones) begin errors++; $display("FAIL hit_bypass: got %0h expected %0h", DisLine, ones); end
        tick(); tick();
        // Last dwell cycle of line 5: write the line being prefetched.
        ready = 1'b1; w_addr = 10'd6; FallLine = pat6;
        tick();
        ready = 1'b0; model[6] = pat6;
        checks++; if (h_addr !== 10'd6) begin errors++; $display("FAIL prefetch_addr: got %0d expected 6", h_addr); end
        checks++; if (DisLine !== pat6) begin errors++; $display("FAIL prefetch_bypass: got %0h expected %0h", DisLine, pat6); end
        wait_h(5);
        checks++; if (DisLine !== ones) begin errors++; $display("FAIL line5_persist: got %0h expected %0h", DisLine, ones); end
        wait_h(6);
        checks++; if (DisLine !== pat6) begin errors++; $display("FAIL line6_persist: got %0h expected %0h", DisLine, pat6); end
    endtask

    task automatic test_pixel();
        vga_x = 10'd5; vga_y = 9'd0;
        ready = 1'b1; w_addr = 10'd5; FallLine = '0;
        tick();
        ready = 1'b0; model[5] = '0;
        checks++; if (pix !== 1'b1) begin errors++; $display("FAIL pix_rbw_old: got %0b expected 1", pix); end
        tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL pix_rbw_new: got %0b expected 0", pix); end
        vga_x = 10'd6; vga_y = 9'd479; tick();
        checks++; if (pix !== 1'b1) begin errors++; $display("FAIL pix_6_479: got %0b expected 1", pix); end
        vga_y = 9'd1; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL pix_6_1: got %0b expected 0", pix); end
        vga_y = 9'd480; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL pix_y_range: got %0b expected 0", pix); end
        vga_x = 10'd7; vga_y = 9'd0; tick();
        checks++; if (pix !== 1'b1) begin errors++; $display("FAIL pix_7_0: got %0b expected 1", pix); end
        vga_y = 9'd3; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL pix_7_3: got %0b expected 0", pix); end
        vga_x = 10'd700; vga_y = 9'd2; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL pix_x_range: got %0b expected 0", pix); end
    endtask

    task automatic test_bad_waddr();
        ready = 1'b1; w_addr = 10'd700; FallLine = ones;
        tick();
        ready = 1'b0;
        checks++; if (DisLine !== model[h_addr]) begin
            errors++; $display("FAIL bad_waddr_disline: got %0h expected %0h", DisLine, model[h_addr]);
        end
        vga_x = 10'd60; vga_y = 9'd1; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL bad_waddr_alias: got %0b expected 0", pix); end
    endtask

    task automatic test_mid_reset();
        wait_h(300);
        tick();
        rst = 1'b1; ready = 1'b1; w_addr = 10'd10; FallLine = ones;
        tick();
        rst = 1'b0; ready = 1'b0;
        checks++; if (h_addr !== '0) begin errors++; $display("FAIL midrst_h_addr: got %0d expected 0", h_addr); end
        checks++; if (DisLine !== '0) begin errors++; $display("FAIL midrst_DisLine: got %0h expected 0", DisLine); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL midrst_sweep_done: got %0b expected 0", sweep_done); end
        tick(); tick(); tick();
        checks++; if (h_addr !== '0) begin errors++; $display("FAIL midrst_dwell0: got %0d expected 0", h_addr); end
        tick();
`ifdef LINE_STORE_CLEAR_ON_RESET_EN
        checks++; if (h_addr !== '0 || DisLine !== '0) begin
            errors++; $display("FAIL midrst_clear: h_addr=%0d DisLine=%0h expected 0 and 0", h_addr, DisLine);
        end
`else
        checks++; if (h_addr !== 10'd1) begin errors++; $display("FAIL midrst_step1: got %0d expected 1", h_addr); end
        checks++; if (DisLine !== model[1]) begin errors++; $display("FAIL midrst_line1: got %0h expected %0h", DisLine, model[1]); end
        vga_x = 10'd10; vga_y = 9'd0; tick();
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL midrst_write_dropped: got %0b expected 0", pix); end
        vga_y = 9'd1; tick();
        checks++; if (pix !== 1'b1) begin errors++; $display("FAIL midrst_line10_bit1: got %0b expected 1", pix); end
        wait_h(300);
        checks++; if (DisLine !== model[300]) begin
            errors++; $display("FAIL midrst_contents: got %0h expected %0h", DisLine, model[300]);
        end
`endif
    endtask

    initial begin
        ones = '1;
        pat6 = ~W'(6);
        for (int k = 0; k < L; k++) model[k] = '0;
        test_reset();
`ifdef LINE_STORE_CLEAR_ON_RESET_EN
        test_clear();
`endif
        test_preload();
        test_sweep();
        test_write_bypass();
        test_pixel();
        test_bad_waddr();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_store_ctrl.md
Name: line_store_ctrl

Overview:
- Owns the 640-line x 480-bit playfield line store.
- Acts as the responder end of the line-update interface used by the falling-line / font-insert writer:
  - sweeps the line address `h_addr` and presents `DisLine` for that address;
  - accepts write-backs on `ready` / `w_addr` / `FallLine`.
- Also serves a registered pixel read port to the VGA output stage.

Parameters:
- `LINES`, 640, number of stored lines (sweep range 0..LINES-1)
- `WIDTH`, 480, bits per line
- `AW`, 10, line address width
- `HOLD`, 4, cycles each `h_addr` value is held; must be >= 2 (elaboration error otherwise)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `h_addr`  out  AW  current sweep line address
- `DisLine`  out  WIDTH  stored content of line `h_addr`, bit 0 = first pixel
- `FallLine`  in  WIDTH  write-back data from writer
- `w_addr`  in  AW  write-back line address
- `ready`  in  1  write strobe; one line written per cycle it is high
- `vga_x`  in  AW  pixel query, line index
- `vga_y`  in  9  pixel query, bit index within line
- `pix`  out  1  queried pixel, one cycle latency
- `sweep_done`  out  1  one-cycle pulse when the sweep wraps to 0

Behaviour:
- Reset values:
  - `h_addr` = 0, `DisLine` = 0, `pix` = 0, `sweep_done` = 0, dwell counter = 0, state = SWEEP.
  - CLEAR replaces SWEEP as the post-reset state when the macro is enabled.
- `rst` mid-operation: the sweep restarts at 0 and in-flight writes are dropped. Store contents are untouched unless the macro is enabled.
- States: SWEEP, CLEAR (macro only). No other states.
- Sweep:
  - Dwell counter counts 0..HOLD-1. At HOLD-1, `h_addr` advances: `h_addr`+1, or 0 after LINES-1.
  - The next line is prefetched in the last dwell cycle, so `h_addr` and `DisLine` change in the same cycle.
  - `DisLine` always equals mem[`h_addr`] as of that cycle.
- `sweep_done` is high for exactly the one cycle in which `h_addr` becomes 0 after LINES-1. It does not pulse on the first cycle after reset.
- Write port:
  - `ready`=1 at cycle t writes `FallLine` to mem[`w_addr`]; the write is visible from t+1.
  - `w_addr` >= LINES is ignored.
  - Writes are accepted in every SWEEP cycle, independent of the dwell phase.
- Bypass:
  - If `w_addr` equals the current `h_addr`, `DisLine` shows `FallLine` from t+1.
  - If `w_addr` equals the address being prefetched, the prefetched value is `FallLine`.
  - Write wins over a simultaneous read of the same line.
- Pixel port:
  - `pix`(t+1) = mem[`vga_x`][`vga_y`] as of cycle t, read-before-write, so a same-cycle write to `vga_x` returns old data.
  - `vga_x` >= LINES or `vga_y` >= WIDTH gives `pix` = 0.
- Widths: the dwell counter is sized clog2(HOLD); address arithmetic wraps explicitly at LINES, never at 2^AW.

Optional Feature:
- `LINE_STORE_CLEAR_ON_RESET_EN` defined:
  - After `rst` deasserts, state CLEAR writes zero to one line per cycle, lines 0..LINES-1 (LINES cycles).
  - During CLEAR: `h_addr` = 0, `DisLine` = 0, `pix` = 0, and `ready` writes are ignored.
  - CLEAR then enters SWEEP at `h_addr` 0 with `DisLine` = 0.
- Undefined: no CLEAR state; store contents are preserved across reset (power-up content per RAM init).

Decomposition:
- Package `line_store_pkg`: LINES, WIDTH, AW, pixel-index width, state enum {SWEEP, CLEAR}.
- One sub-module `line_ram`: 1 write port, 2 registered read ports (sweep prefetch, pixel), read-before-write. Implemented as replicated simple-dual-port RAM if needed.
- Sweep FSM, bypass muxing and range checks live in the top.

Test Plan:
- Reset, no writes, mem preloaded with line k = k -> `h_addr` steps 0,1,2,... every 4 cycles; `DisLine` == k in the same cycle `h_addr` == k; `sweep_done` pulses once at the 639->0 wrap, 2560 cycles per sweep.
- `ready`=1, `w_addr`=5, `FallLine`=all-ones while `h_addr`=5 -> `DisLine` all-ones from the next cycle; the following sweep also shows line 5 all-ones.
- Write to line 6 in the prefetch cycle of line 5 -> `DisLine` at `h_addr`=6 shows the new value, not stale data.
- `vga_x`=5, `vga_y`=0, same cycle as a write of 0 to line 5 whose old bit 0 = 1 -> `pix`=1 next cycle, `pix`=0 on the following query; `vga_y`=480 -> `pix`=0.
- `w_addr`=700 with `ready`=1 -> no line changes; `rst` at `h_addr`=300 -> `h_addr`=0 next cycle, contents intact.
- With `LINE_STORE_CLEAR_ON_RESET_EN`: preload ones, reset -> 640 CLEAR cycles with `ready` ignored, then every `DisLine` = 0 through a full sweep.
